// File: rtl/pe_psum_accum.sv
// Partial-sum accumulator: loads a bias, adds a configured number of signed beats with saturation, then presents the result.
// Latency: result valid 1 cycle after the last accepted beat; back-to-back starts are accepted on the result handshake.
module pe_psum_accum #(
    parameter int ASUMDWD = 17,
    parameter int ACCWD   = 20,
    parameter int CNTWD   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [CNTWD-1:0]         i_len,
    input  logic signed [ACCWD-1:0]  i_bias,
    input  logic signed [ASUMDWD-1:0] i_sum,
    input  logic                     i_sum_valid,
    output logic                     o_sum_ready,
    output logic signed [ACCWD-1:0]  o_psum,
    output logic                     o_sat,
    output logic                     o_psum_valid,
    input  logic                     i_psum_ready
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                  state;
    logic signed [ACCWD-1:0] acc;
    logic [CNTWD:0]          cnt;
    logic                    sat;

    logic signed [ACCWD:0]   acc_ext;
    logic signed [ACCWD:0]   sum_ext;
    logic signed [ACCWD:0]   sum_wide;
    logic                    ovf;
    logic signed [ACCWD-1:0] sum_sat;
    logic                    beat;
    logic                    cfg_take;
    logic [CNTWD:0]          len_load;

    // One guard bit is enough: a sign-extended ASUMDWD addend cannot overflow ACCWD+1 bits.
    assign acc_ext  = {acc[ACCWD-1], acc};
    assign sum_ext  = {{(ACCWD+1-ASUMDWD){i_sum[ASUMDWD-1]}}, i_sum};
    assign sum_wide = acc_ext + sum_ext;
    assign ovf      = sum_wide[ACCWD] ^ sum_wide[ACCWD-1];

    always_comb begin
        sum_sat = sum_wide[ACCWD-1:0];
        if (ovf) begin
            sum_sat = sum_wide[ACCWD] ? {1'b1, {(ACCWD-1){1'b0}}} : {1'b0, {(ACCWD-1){1'b1}}};
        end
    end

    assign len_load = (i_len == '0) ? {1'b1, {CNTWD{1'b0}}} : {1'b0, i_len};
    assign beat     = i_sum_valid && (state == ACC);

    // o_cfg_ready is a pure state decode; in OUT a start only takes effect together
    // with the result handshake so a pending result is never dropped.
    assign cfg_take = i_cfg_valid && ((state == IDLE) || ((state == OUT) && i_psum_ready));

    assign o_cfg_ready  = (state == IDLE) || (state == OUT);
    assign o_sum_ready  = (state == ACC);
    assign o_psum_valid = (state == OUT);
    assign o_psum       = acc;
    assign o_sat        = sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_take) begin
                        state <= ACC;
                        acc   <= i_bias;
                        cnt   <= len_load;
                        sat   <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= sum_sat;
                        cnt <= cnt - 1'b1;
                        if (ovf) begin
                            sat <= 1'b1;
                        end
                        if (cnt == {{CNTWD{1'b0}}, 1'b1}) begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (cfg_take) begin
                        state <= ACC;
                        acc   <= i_bias;
                        cnt   <= len_load;
                        sat   <= 1'b0;
                    end else if (i_psum_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_psum_accum.sv
// Bench for pe_psum_accum: directed scenarios plus random transactions checked against an arithmetic reference model.
module tb_pe_psum_accum;

    localparam int ASUMDWD = 17;
    localparam int ACCWD   = 20;
    localparam int CNTWD   = 8;
    localparam longint ACC_MAX = (64'sd1 <<< (ACCWD-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACCWD-1));

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      i_cfg_valid;
    logic                      o_cfg_ready;
    logic [CNTWD-1:0]          i_len;
    logic signed [ACCWD-1:0]   i_bias;
    logic signed [ASUMDWD-1:0] i_sum;
    logic                      i_sum_valid;
    logic                      o_sum_ready;
    logic signed [ACCWD-1:0]   o_psum;
    logic                      o_sat;
    logic                      o_psum_valid;
    logic                      i_psum_ready;

    int total = 0;
    int bad   = 0;
    int bq[$];

    pe_psum_accum #(.ASUMDWD(ASUMDWD), .ACCWD(ACCWD), .CNTWD(CNTWD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_len        (i_len),
        .i_bias       (i_bias),
        .i_sum        (i_sum),
        .i_sum_valid  (i_sum_valid),
        .o_sum_ready  (o_sum_ready),
        .o_psum       (o_psum),
        .o_sat        (o_sat),
        .o_psum_valid (o_psum_valid),
        .i_psum_ready (i_psum_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: bias plus each beat, clamped to the accumulator range after every addition.
    function automatic void model(input longint bias, output longint res, output logic s);
        longint a;
        a = bias;
        s = 1'b0;
        foreach (bq[i]) begin
            a = a + bq[i];
            if (a > ACC_MAX) begin a = ACC_MAX; s = 1'b1; end
            if (a < ACC_MIN) begin a = ACC_MIN; s = 1'b1; end
        end
        res = a;
    endfunction

    task automatic start(input int len, input int bias);
        int n;
        n = 0;
        while (!o_cfg_ready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("cfg_ready_timeout", 0, 1);
        i_cfg_valid = 1'b1;
        i_len       = len[CNTWD-1:0];
        i_bias      = bias[ACCWD-1:0];
        tick();
        i_cfg_valid = 1'b0;
    endtask

    // Sends bq with random gaps; checks no early result while beats remain.
    task automatic send_beats(input int max_gap, input bit early_chk);
        for (int i = 0; i < bq.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin i_sum_valid = 1'b0; tick(); end
            i_sum_valid = 1'b1;
            i_sum       = bq[i][ASUMDWD-1:0];
            i_cfg_valid = (i != bq.size() - 1) && ($urandom_range(0, 3) == 0);
            i_bias      = $urandom;
            tick();
            i_sum_valid = 1'b0;
            i_cfg_valid = 1'b0;
            if (early_chk && i != bq.size() - 1) chk("no_early_valid", o_psum_valid, 0);
        end
    endtask

    task automatic check_result(input string tag, input int bias, input int stall);
        longint exp_res;
        logic   exp_sat;
        model(bias, exp_res, exp_sat);
        chk({tag, "_valid"}, o_psum_valid, 1);
        chk({tag, "_psum"}, o_psum, exp_res);
        chk({tag, "_sat"}, o_sat, exp_sat);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({tag, "_hold_valid"}, o_psum_valid, 1);
            chk({tag, "_hold_psum"}, o_psum, exp_res);
        end
    endtask

    task automatic handshake();
        i_psum_ready = 1'b1;
        tick();
        i_psum_ready = 1'b0;
        chk("after_hs_valid", o_psum_valid, 0);
    endtask

    initial begin
        int len, bias;
        rst_n = 1'b0; i_cfg_valid = 1'b0; i_len = '0; i_bias = '0;
        i_sum = '0; i_sum_valid = 1'b0; i_psum_ready = 1'b0;
        #12;
        chk("rst_psum", o_psum, 0);
        chk("rst_valid", o_psum_valid, 0);
        chk("rst_sum_ready", o_sum_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_cfg_ready", o_cfg_ready, 1);
        chk("rst_sat", o_sat, 0);

        // Beats in IDLE are ignored.
        i_sum_valid = 1'b1; i_sum = 17'sd99;
        repeat (3) tick();
        i_sum_valid = 1'b0;
        chk("idle_ignore_psum", o_psum, 0);
        chk("idle_ignore_valid", o_psum_valid, 0);

        // Basic accumulate.
        start(4, 10);
        chk("acc_sum_ready", o_sum_ready, 1);
        chk("acc_cfg_ready", o_cfg_ready, 0);
        bq = '{5, -3, 100, -7};
        send_beats(0, 1);
        chk("basic_psum_lit", o_psum, 105);
        check_result("basic", 10, 0);
        handshake();

        // Positive saturation.
        start(3, 524000);
        bq = '{200, 200, -50};
        send_beats(0, 1);
        chk("possat_psum_lit", o_psum, 524237);
        chk("possat_sat_lit", o_sat, 1);
        handshake();

        // Gap between beats, then backpressure, then back-to-back start.
        start(2, 0);
        i_sum_valid = 1'b1; i_sum = 17'sd7; tick();
        i_sum_valid = 1'b0;
        repeat (3) begin tick(); chk("gap_no_valid", o_psum_valid, 0); end
        i_sum_valid = 1'b1; i_sum = 17'sd8; tick();
        i_sum_valid = 1'b0;
        bq = '{7, 8};
        check_result("gap", 0, 5);
        chk("gap_psum_lit", o_psum, 15);
        i_psum_ready = 1'b1; i_cfg_valid = 1'b1; i_len = 8'd1; i_bias = -20'sd1;
        tick();
        i_psum_ready = 1'b0; i_cfg_valid = 1'b0;
        chk("b2b_sum_ready", o_sum_ready, 1);
        chk("b2b_valid_low", o_psum_valid, 0);
        i_sum_valid = 1'b1; i_sum = -17'sd65536; tick();
        i_sum_valid = 1'b0;
        chk("b2b_psum", o_psum, -65537);
        chk("b2b_valid", o_psum_valid, 1);
        handshake();

        // Length 0 means 256 beats.
        start(0, 0);
        bq.delete();
        repeat (256) bq.push_back(1);
        send_beats(0, 1);
        check_result("wrap", 0, 0);
        handshake();

        // Reset in the middle of an accumulation.
        start(4, 10);
        bq = '{1, 2};
        send_beats(0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_psum", o_psum, 0);
        chk("midrst_sum_ready", o_sum_ready, 0);
        chk("midrst_valid", o_psum_valid, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("midrst_cfg_ready", o_cfg_ready, 1);
        i_sum_valid = 1'b1; i_sum = 17'sd3;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("midrst_no_valid", o_psum_valid, 0);
        end
        i_sum_valid = 1'b0;

        // Random transactions, including near-limit biases to exercise both saturation directions.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, 8);
            case ($urandom_range(0, 2))
                0: bias = $urandom_range(0, 1000000) - 500000;
                1: bias = 524287 - $urandom_range(0, 100000);
                default: bias = -524288 + $urandom_range(0, 100000);
            endcase
            bq.delete();
            for (int b = 0; b < len; b++) bq.push_back(int'($urandom_range(0, 131071)) - 65536);
            start(len, bias);
            send_beats(2, 1);
            check_result("rand", bias, $urandom_range(0, 3));
            handshake();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
